nanci_edge_tx: RTL and testbench

Boundary transmitter for the Nanci PE mesh. It drives one neighbor-input port (`i_PE_l`/`i_PE_r`/`i_PE_u`/`i_PE_d`) of an edge PE. Host-side words of the form {address, data} are buffered in a small FIFO and presented one per compute step. When no word is available, the port is padded with `MAX_INT`, so the PE's select/compare logic treats the missing neighbor as "infinitely large". One instance exists per open mesh edge port.

---
 rtl/nanci_edge_tx.sv | 124 ++++++++++++
 tb/tb_nanci_edge_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nanci_edge_tx.sv
// Boundary transmitter for an open Nanci mesh edge port: buffers host {addr,data}
// words in a small FIFO and presents one per PE step, padding with MAX_INT when empty.
module nanci_edge_tx #(
   parameter int ADDR_WIDTH     = 3,
   parameter int DATA_WIDTH     = 3,
   parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
   parameter int COMPUTE_CYCLES = 1,
   parameter int DEPTH          = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_valid,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_word,
   output logic                             o_ready,
   input  logic                             i_en,
   input  logic                             i_flush,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
   output logic                             o_step,
   output logic                             o_underflow,
   output logic [$clog2(DEPTH):0]           o_count
);

   localparam int W  = ADDR_WIDTH + DATA_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
   localparam logic [PW-1:0] LAST_PHASE = PW'(COMPUTE_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   state_t          next_state;
   logic [PW-1:0]   phase;
   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            boundary;
   logic            push;
   logic            pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (i_flush)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (i_en)  next_state = RUN;
         RUN:  if (!i_en) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Pop decisions use the registered count, so a word pushed on a boundary cycle waits for the next step.
   always_comb begin
      boundary = (state == RUN) && (phase == LAST_PHASE);
      push     = i_valid && o_ready && !i_flush;
      pop      = boundary && (count != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         phase <= '0;
      else if (i_flush)
         phase <= '0;
      else if (state == RUN && next_state == RUN)
         phase <= boundary ? '0 : phase + PW'(1);
      else
         phase <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= i_word;
   end

   // Neighbor word and pulses only move on step boundaries so the PE sees a constant input per step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_PE        <= MAX_INT;
         o_step      <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_flush) begin
         o_PE        <= MAX_INT;
         o_step      <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_step      <= boundary;
         o_underflow <= boundary && (count == '0);
         if (boundary)
            o_PE <= (count != '0) ? mem[rd_ptr] : MAX_INT;
      end
   end

   assign o_ready = (count < CW'(DEPTH));
   assign o_count = count;

endmodule

// File: tb/tb_nanci_edge_tx.sv
// Bench for nanci_edge_tx: two instances (COMPUTE_CYCLES 1 and 3) checked every cycle
// against a queue-based scoreboard, plus directed spot checks from the test plan.
module tb_nanci_edge_tx;

   localparam int CCS [2] = '{1, 3};
   localparam logic [5:0] MAXV = 6'h3F;

   logic clk = 1'b0;
   logic rst;
   logic v [2];
   logic en [2];
   logic fl [2];
   logic [5:0] wd [2];

   logic [5:0] pe0, pe1;
   logic rdy0, rdy1, stp0, stp1, ufl0, ufl1;
   logic [2:0] cnt0, cnt1;

   int errors = 0;
   int checks = 0;
   int steps1 = 0;

   // Scoreboard state per instance
   logic [5:0] q0 [$];
   logic [5:0] q1 [$];
   int mst [2];
   int mph [2];
   logic [5:0] mpe [2];
   logic mstep [2];
   logic muf [2];

   always #5 clk = ~clk;

   nanci_edge_tx #(.COMPUTE_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .i_valid(v[0]), .i_word(wd[0]), .o_ready(rdy0),
      .i_en(en[0]), .i_flush(fl[0]), .o_PE(pe0), .o_step(stp0),
      .o_underflow(ufl0), .o_count(cnt0));

   nanci_edge_tx #(.COMPUTE_CYCLES(3)) dut1 (
      .clk(clk), .rst(rst), .i_valid(v[1]), .i_word(wd[1]), .o_ready(rdy1),
      .i_en(en[1]), .i_flush(fl[1]), .o_PE(pe1), .o_step(stp1),
      .o_underflow(ufl1), .o_count(cnt1));

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qpush(input int k, input logic [5:0] w);
      if (k == 0) q0.push_back(w); else q1.push_back(w);
   endtask

   task automatic qpop(input int k, output logic [5:0] w);
      if (k == 0) w = q0.pop_front(); else w = q1.pop_front();
   endtask

   task automatic resetModel();
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         mst[k] = 0; mph[k] = 0; mpe[k] = MAXV; mstep[k] = 1'b0; muf[k] = 1'b0;
      end
   endtask

   // Advances the reference model of instance k by one clock edge using the inputs present at that edge.
   task automatic modelEdge(input int k);
      bit bnd;
      bit dopush;
      logic [5:0] w;
      if (fl[k]) begin
         if (k == 0) q0.delete(); else q1.delete();
         mpe[k] = MAXV; mph[k] = 0; mst[k] = 0; mstep[k] = 1'b0; muf[k] = 1'b0;
         return;
      end
      bnd    = (mst[k] == 1) && (mph[k] == CCS[k] - 1);
      dopush = v[k] && (qsize(k) < 4);
      mstep[k] = bnd;
      muf[k]   = bnd && (qsize(k) == 0);
      if (bnd) begin
         if (qsize(k) > 0) begin
            qpop(k, w);
            mpe[k] = w;
         end else begin
            mpe[k] = MAXV;
         end
      end
      if (dopush) qpush(k, wd[k]);
      if (mst[k] == 0) begin
         if (en[k]) mst[k] = 1;
         mph[k] = 0;
      end else if (!en[k]) begin
         mst[k] = 0;
         mph[k] = 0;
      end else begin
         mph[k] = bnd ? 0 : mph[k] + 1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkInst(input int k, input logic [5:0] p, input logic r, input logic s,
                            input logic u, input logic [2:0] c);
      string nm;
      nm = (k == 0) ? "i0" : "i1";
      checkOutput({nm, "_pe"},    {2'b00, p}, {2'b00, mpe[k]});
      checkOutput({nm, "_ready"}, {7'd0, r},  {7'd0, (qsize(k) < 4)});
      checkOutput({nm, "_step"},  {7'd0, s},  {7'd0, mstep[k]});
      checkOutput({nm, "_uflow"}, {7'd0, u},  {7'd0, muf[k]});
      checkOutput({nm, "_count"}, {5'd0, c},  8'(qsize(k)));
   endtask

   task automatic checkAll();
      checkInst(0, pe0, rdy0, stp0, ufl0, cnt0);
      checkInst(1, pe1, rdy1, stp1, ufl1, cnt1);
   endtask

   task automatic applyStimulus(input int k, input logic valid, input logic [5:0] word,
                                input logic enable, input logic flush);
      v[k] = valid; wd[k] = word; en[k] = enable; fl[k] = flush;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         modelEdge(0);
         modelEdge(1);
         #1;
         if (stp1) steps1++;
         checkAll();
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 1'b0, 6'h00, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 6'h00, 1'b0, 1'b0);
      resetModel();
      #2;
      checkAll();
      #10;
      checkAll();
      rst = 1'b0;
      tick(3);

      // Two words then enable, CC=1
      applyStimulus(0, 1'b1, 6'b010000, 1'b0, 1'b0); tick(1);
      applyStimulus(0, 1'b1, 6'b011000, 1'b0, 1'b0); tick(1);
      applyStimulus(0, 1'b0, 6'h00, 1'b1, 1'b0);     tick(1);
      tick(1);
      checkOutput("tp_first_word", {2'b00, pe0}, 8'h10);
      tick(1);
      checkOutput("tp_second_word", {2'b00, pe0}, 8'h18);
      tick(1);
      checkOutput("tp_pad", {2'b00, pe0}, 8'h3F);
      checkOutput("tp_underflow", {7'd0, ufl0}, 8'h01);
      applyStimulus(0, 1'b0, 6'h00, 1'b0, 1'b0);     tick(2);

      // Fill to full; fifth push refused
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1'b1, 6'(6'h21 + i), 1'b0, 1'b0);
         tick(1);
      end
      checkOutput("full_count", {5'd0, cnt0}, 8'd4);
      checkOutput("full_ready", {7'd0, rdy0}, 8'd0);
      applyStimulus(0, 1'b0, 6'h00, 1'b1, 1'b0);     tick(1);
      tick(1);
      checkOutput("after_pop_count", {5'd0, cnt0}, 8'd3);
      checkOutput("after_pop_ready", {7'd0, rdy0}, 8'd1);
      checkOutput("after_pop_pe", {2'b00, pe0}, 8'h21);
      tick(4);

      // Push into empty FIFO on a boundary cycle
      applyStimulus(0, 1'b1, 6'h2A, 1'b1, 1'b0);     tick(1);
      checkOutput("bnd_push_pe", {2'b00, pe0}, 8'h3F);
      checkOutput("bnd_push_count", {5'd0, cnt0}, 8'd1);
      applyStimulus(0, 1'b0, 6'h00, 1'b1, 1'b0);     tick(1);
      checkOutput("bnd_push_next", {2'b00, pe0}, 8'h2A);
      applyStimulus(0, 1'b0, 6'h00, 1'b0, 1'b0);     tick(1);

      // CC=3 instance: steps every third cycle
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1'b1, 6'(6'h11 + i), 1'b0, 1'b0);
         tick(1);
      end
      applyStimulus(1, 1'b0, 6'h00, 1'b1, 1'b0);
      steps1 = 0;
      tick(10);
      checkOutput("cc3_steps_in_10", 8'(steps1), 8'd3);
      checkOutput("cc3_last_word", {2'b00, pe1}, 8'h13);
      applyStimulus(1, 1'b0, 6'h00, 1'b0, 1'b0);     tick(1);

      // Flush mid-run with two words buffered
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1'b1, 6'(6'h31 + i), 1'b0, 1'b0);
         tick(1);
      end
      applyStimulus(1, 1'b0, 6'h00, 1'b1, 1'b0);     tick(4);
      checkOutput("pre_flush_count", {5'd0, cnt1}, 8'd2);
      applyStimulus(1, 1'b1, 6'h3A, 1'b0, 1'b1);     tick(1);
      checkOutput("flush_count", {5'd0, cnt1}, 8'd0);
      checkOutput("flush_pe", {2'b00, pe1}, 8'h3F);
      applyStimulus(1, 1'b0, 6'h00, 1'b0, 1'b0);     tick(3);

      // Asynchronous reset mid-step
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1'b1, 6'(6'h34 + i), 1'b0, 1'b0);
         tick(1);
      end
      applyStimulus(1, 1'b0, 6'h00, 1'b1, 1'b0);     tick(5);
      checkOutput("pre_rst_count", {5'd0, cnt1}, 8'd2);
      #2;
      rst = 1'b1;
      #1;
      resetModel();
      checkOutput("rst_count", {5'd0, cnt1}, 8'd0);
      checkOutput("rst_pe", {2'b00, pe1}, 8'h3F);
      checkOutput("rst_ready", {7'd0, rdy1}, 8'd1);
      checkAll();
      applyStimulus(1, 1'b0, 6'h00, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
